// File: rtl/canny_pkg.sv
// Shared definitions for the Canny hysteresis stage: pixel class encoding,
// binary output levels and the sync-alignment latency.
package canny_pkg;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_WEAK   = 2'd1,
        CLS_STRONG = 2'd2
    } cls_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    localparam logic [7:0] EDGE_ON  = 8'hFF;
    localparam logic [7:0] EDGE_OFF = 8'h00;

    // Register stages between NMS_* and edge_*: classify, window, decide.
    localparam int unsigned HYST_LAT = 3;

    // Strong takes priority, so th_low above th_high produces no weak pixels.
    function automatic cls_t classify(input logic [7:0] data,
                                      input logic [7:0] hi,
                                      input logic [7:0] lo);
        if (data >= hi)
            return CLS_STRONG;
        else if (data >= lo)
            return CLS_WEAK;
        return CLS_NONE;
    endfunction

endpackage

// File: rtl/hyst_linebuf.sv
// Two-row class line buffer: each word packs row y-1 in [1:0] and row y-2
// in [3:2]. Simple dual-port, synchronous read with one-cycle latency.
module hyst_linebuf #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [3:0]    rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_data
);

    logic [3:0] mem [DEPTH];

    // Storage is never reset; stale rows are masked by the row counter.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/canny_hyst.sv
// Canny double threshold + single-pass hysteresis. Classifies each pixel,
// builds a 3x3 class window from two line buffers, and emits 0x00/0xFF for
// source pixel (x-1,y-1) three clocks after the input sync.
// Build option: define HYST_8CONN_EN for 8-connected promotion; default
// build promotes weak pixels from N/S/E/W strong neighbours only.
module canny_hyst
    import canny_pkg::*;
#(
    parameter int unsigned IMG_W = 640
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] NMS_data,
    input  logic       NMS_hs,
    input  logic       NMS_vs,
    input  logic       NMS_de,
    input  logic [7:0] th_high,
    input  logic [7:0] th_low,
    output logic [7:0] edge_data,
    output logic       edge_hs,
    output logic       edge_vs,
    output logic       edge_de
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic [7:0]    sh_high, sh_low;
    logic          vs_d, de_d;
    logic          vs_rise, de_fall;
    logic [CW-1:0] col, col_s1, col_s2;
    logic [1:0]    row, row_s1, row_s2;
    sync_t         sync_pipe [HYST_LAT];
    cls_t          cls_s1;
    logic [3:0]    lb_rd, lb_wr;
    cls_t          win_top [3];
    cls_t          win_mid [3];
    cls_t          win_bot [3];
    cls_t          nb_n, nb_s, nb_e, nb_w;
    logic          strong_nb, edge_hit;

    assign vs_rise = NMS_vs & ~vs_d;
    assign de_fall = ~NMS_de & de_d;

    // Sync edge detectors and per-frame threshold shadows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d    <= 1'b0;
            de_d    <= 1'b0;
            sh_high <= 8'hFF;
            sh_low  <= 8'hFF;
        end else begin
            vs_d <= NMS_vs;
            de_d <= NMS_de;
            if (vs_rise) begin
                sh_high <= th_high;
                sh_low  <= th_low;
            end
        end
    end

    // Column and saturating row position of the incoming pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else begin
            if (NMS_de)
                col <= col + CW'(1);
            else if (de_fall)
                col <= '0;
            if (vs_rise)
                row <= '0;
            else if (de_fall && row != 2'd3)
                row <= row + 2'd1;
        end
    end

    // Sync delay line aligned with the three data stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < HYST_LAT; i++)
                sync_pipe[i] <= '0;
        end else begin
            sync_pipe[0] <= '{hs: NMS_hs, vs: NMS_vs, de: NMS_de};
            for (int unsigned i = 1; i < HYST_LAT; i++)
                sync_pipe[i] <= sync_pipe[i-1];
        end
    end

    // Stage 1: classify with the frame thresholds and tag with position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_s1 <= CLS_NONE;
            col_s1 <= '0;
            row_s1 <= '0;
        end else if (NMS_de) begin
            cls_s1 <= classify(NMS_data, sh_high, sh_low);
            col_s1 <= col;
            row_s1 <= row;
        end
    end

    // Read for stage 2 is issued with the input pixel; the write-back one
    // cycle later ages row y-1 into the y-2 slot and stores row y.
    assign lb_wr = {lb_rd[1:0], cls_s1};

    hyst_linebuf #(
        .DEPTH (IMG_W),
        .AW    (CW)
    ) u_linebuf (
        .clk     (clk),
        .rd_en   (NMS_de),
        .rd_addr (col),
        .rd_data (lb_rd),
        .wr_en   (sync_pipe[0].de),
        .wr_addr (col_s1),
        .wr_data (lb_wr)
    );

    // Stage 2: shift the new column (rows y-2, y-1, y) into the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                win_top[i] <= CLS_NONE;
                win_mid[i] <= CLS_NONE;
                win_bot[i] <= CLS_NONE;
            end
            col_s2 <= '0;
            row_s2 <= '0;
        end else if (sync_pipe[0].de) begin
            win_top[0] <= cls_t'(lb_rd[3:2]);
            win_mid[0] <= cls_t'(lb_rd[1:0]);
            win_bot[0] <= cls_s1;
            for (int unsigned i = 1; i < 3; i++) begin
                win_top[i] <= win_top[i-1];
                win_mid[i] <= win_mid[i-1];
                win_bot[i] <= win_bot[i-1];
            end
            col_s2 <= col_s1;
            row_s2 <= row_s1;
        end
    end

    // Stage 3 decision on window centre, masking invalid row/column edges.
    always_comb begin
        nb_n      = (row_s2 < 2'd2) ? CLS_NONE : win_top[1];
        nb_s      = win_bot[1];
        nb_e      = win_mid[0];
        nb_w      = (col_s2 < CW'(2)) ? CLS_NONE : win_mid[2];
        strong_nb = (nb_n == CLS_STRONG) || (nb_s == CLS_STRONG) ||
                    (nb_e == CLS_STRONG) || (nb_w == CLS_STRONG);
`ifdef HYST_8CONN_EN
        if (row_s2 >= 2'd2 && win_top[0] == CLS_STRONG)
            strong_nb = 1'b1;
        if (row_s2 >= 2'd2 && col_s2 >= CW'(2) && win_top[2] == CLS_STRONG)
            strong_nb = 1'b1;
        if (win_bot[0] == CLS_STRONG)
            strong_nb = 1'b1;
        if (col_s2 >= CW'(2) && win_bot[2] == CLS_STRONG)
            strong_nb = 1'b1;
`endif
        edge_hit = (win_mid[1] == CLS_STRONG) ||
                   ((win_mid[1] == CLS_WEAK) && strong_nb);
    end

    // Output register: zero outside de and on the first row/column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            edge_data <= EDGE_OFF;
        else if (sync_pipe[1].de && col_s2 != '0 && row_s2 != '0 && edge_hit)
            edge_data <= EDGE_ON;
        else
            edge_data <= EDGE_OFF;
    end

    assign edge_hs = sync_pipe[HYST_LAT-1].hs;
    assign edge_vs = sync_pipe[HYST_LAT-1].vs;
    assign edge_de = sync_pipe[HYST_LAT-1].de;

endmodule

// File: tb/tb_canny_hyst.sv
// Self-checking bench for canny_hyst: directed and random frames compared
// cycle by cycle against a frame-level hysteresis model.
module tb_canny_hyst;

    localparam int W    = 8;
    localparam int MAXH = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] NMS_data = '0;
    logic       NMS_hs = 1'b0, NMS_vs = 1'b0, NMS_de = 1'b0;
    logic [7:0] th_high = 8'd10, th_low = 8'd5;
    logic [7:0] edge_data;
    logic       edge_hs, edge_vs, edge_de;

    always #5 clk = ~clk;

    canny_hyst #(.IMG_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .NMS_data  (NMS_data),
        .NMS_hs    (NMS_hs),
        .NMS_vs    (NMS_vs),
        .NMS_de    (NMS_de),
        .th_high   (th_high),
        .th_low    (th_low),
        .edge_data (edge_data),
        .edge_hs   (edge_hs),
        .edge_vs   (edge_vs),
        .edge_de   (edge_de)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    string       cur_tag  = "reset";
    logic [10:0] exp_q [$];
    logic [7:0]  src [MAXH][W];
    logic [7:0]  fr_hi, fr_lo;
    int          fr_h;

    // Class of a source pixel in the current frame; outside the frame is none.
    function automatic int cls_at(input int x, input int y);
        if (x < 0 || y < 0 || x >= W || y >= fr_h) return 0;
        if (src[y][x] >= fr_hi) return 2;
        if (src[y][x] >= fr_lo) return 1;
        return 0;
    endfunction

    function automatic bit is_edge(input int x, input int y);
        int c;
        c = cls_at(x, y);
        if (c == 2) return 1'b1;
        if (c != 1) return 1'b0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
                if (dx == 0 && dy == 0) continue;
`ifndef HYST_8CONN_EN
                if (dx != 0 && dy != 0) continue;
`endif
                if (cls_at(x + dx, y + dy) == 2) return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One pixel clock: drive inputs, queue the expected output, compare the
    // output due now (two queued entries ahead = three register stages).
    task automatic step(input logic hs, input logic vs, input logic de,
                        input logic [7:0] d, input logic [7:0] ed);
        logic [10:0] expv;
        NMS_hs = hs; NMS_vs = vs; NMS_de = de; NMS_data = d;
        if (rst_n) exp_q.push_back({hs, vs, de, ed});
        else       exp_q.push_back('0);
        @(posedge clk);
        #1;
        expv = exp_q.pop_front();
        check(cur_tag, {edge_hs, edge_vs, edge_de, edge_data}, expv);
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        foreach (exp_q[i]) exp_q[i] = '0;
        #1;
        check("async_rst", {edge_hs, edge_vs, edge_de, edge_data}, 11'h000);
        repeat (3) step(1'b0, 1'b0, 1'b1, 8'd200, 8'h00);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic frame(input string tag, input int h, input bit use_vs,
                         input int rst_line, input int chg_line, input logic [7:0] chg_hi);
        cur_tag = tag;
        fr_h    = h;
        if (use_vs) begin
            fr_hi = th_high;
            fr_lo = th_low;
            step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
            step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        end else begin
            fr_hi = 8'hFF;
            fr_lo = 8'hFF;
        end
        repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int y = 0; y < h; y++) begin
            if (y == chg_line) th_high = chg_hi;
            for (int x = 0; x < W; x++) begin
                if (y == rst_line && x == 3) begin
                    mid_reset();
                    return;
                end
                step(1'b0, 1'b0, 1'b1, src[y][x],
                     (x > 0 && y > 0 && is_edge(x - 1, y - 1)) ? 8'hFF : 8'h00);
            end
            step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
            repeat ($urandom_range(1, 4)) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        repeat (4) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int y = 0; y < MAXH; y++)
            for (int x = 0; x < W; x++)
                src[y][x] = v;
    endtask

    task automatic rand_fill();
        for (int y = 0; y < MAXH; y++)
            for (int x = 0; x < W; x++)
                case ($urandom_range(0, 5))
                    0, 1:    src[y][x] = 8'd0;
                    2:       src[y][x] = 8'd70;
                    3:       src[y][x] = 8'd150;
                    4:       src[y][x] = 8'd200;
                    default: src[y][x] = 8'($urandom_range(0, 255));
                endcase
    endtask

    initial begin
        exp_q.push_back('0);
        exp_q.push_back('0);

        // Reset held while de toggles; outputs must stay zero.
        repeat (4) step(1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)), 8'h00);
        rst_n = 1'b1;

        // No vs yet: thresholds are still the 0xFF reset shadows.
        for (int y = 0; y < MAXH; y++)
            for (int x = 0; x < W; x++)
                src[y][x] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'hFE;
        frame("shadow_rst", 3, 1'b0, -1, -1, 8'h00);

        th_high = 8'd100;
        th_low  = 8'd50;
        fill(8'd200);
        frame("strong_only", 4, 1'b1, -1, -1, 8'h00);

        fill(8'd0);
        src[2][3] = 8'd70;
        frame("isolated_weak", 5, 1'b1, -1, -1, 8'h00);

        src[3][4] = 8'd150;
        frame("conn_diag", 5, 1'b1, -1, -1, 8'h00);

        src[3][3] = 8'd150;
        frame("conn_south", 5, 1'b1, -1, -1, 8'h00);

        rand_fill();
        frame("th_change", 5, 1'b1, -1, 2, 8'd250);

        fill(8'd200);
        frame("th_next", 4, 1'b1, -1, -1, 8'h00);

        th_high = 8'd120;
        th_low  = 8'd60;
        fill(8'd200);
        frame("mid_reset", 6, 1'b1, 2, -1, 8'h00);

        fill(8'd0);
        src[1][2] = 8'd70;
        src[1][5] = 8'd70;
        src[2][4] = 8'd70;
        frame("stale_rows", 4, 1'b1, -1, -1, 8'h00);

        for (int f = 0; f < 6; f++) begin
            th_high = 8'($urandom_range(80, 220));
            th_low  = 8'($urandom_range(20, 180));
            rand_fill();
            frame("random", $urandom_range(3, MAXH), 1'b1, -1, -1, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
